dcnn_s1_pkt_dispatch: RTL and testbench
=======================================

// Module: dcnn_s1_pkt_dispatch
// PURPOSE
//  Core-clock packet parser directly downstream of the stage-0 IO interface; consumes one DW-bit core_vld/core_rdy
//  word stream (one instance per channel). Decodes a header word, then routes the payload to the kernel-buffer
//  write port, the feature-map stream, or the config register; drops reserved packets and flags them.
// PARAMETERS
//  DW   32  stream/data width (>=32)
//  KAW  11  kernel-buffer address width (<=DW-18)
// PORTS
//  clk        in   1    core clock
//  arst       in   1    async reset, active-high
//  in_data    in   DW   word from stage-0 core_data
//  in_vld     in   1    word valid
//  in_rdy     out  1    word accepted when in_vld&in_rdy
//  kw_en      out  1    kernel-buffer write strobe
//  kw_addr    out  KAW  kernel-buffer write address
//  kw_data    out  DW   kernel-buffer write data
//  fm_data    out  DW   feature-map word
//  fm_vld     out  1    feature-map valid
//  fm_rdy     in   1    feature-map ready
//  cfg_word   out  DW   last config payload word
//  cfg_upd    out  1    1-cycle pulse when cfg_word updates
//  pkt_done   out  1    1-cycle pulse on packet completion
//  err_type   out  1    sticky: reserved packet type seen
//  err_cksum  out  1    sticky: checksum mismatch (0 without DCNN_S1_CKSUM_EN)
// BEHAVIOUR
//  Header: [DW-1:DW-2] type (00 KER, 01 FEAT, 10 CFG, 11 RSVD), [KAW+15:16] base addr, [15:0] LEN payload words.
//  Reset: state=HDR, all counters 0, kw_en/cfg_upd/pkt_done/err_*=0, kw_addr/kw_data/cfg_word=0.
//  FSM: HDR -> KER|FEAT|CFG|DROP on header accept; LEN=0 -> PKT_END (or CKS), no payload consumed.
//   Payload states -> PKT_END (or CKS) when the accepted word count reaches LEN; CKS -> PKT_END on the trailer accept.
//   PKT_END: in_rdy=0 for one cycle, pkt_done=1, -> HDR. One-cycle header bubble per packet is required.
//  HDR: in_rdy=1; latch type, base, LEN; rem<=LEN.
//  KER: in_rdy=1; each accept -> next cycle kw_en=1, kw_data=word, kw_addr=base+idx mod 2^KAW (wraps silently).
//  FEAT: zero-latency pass-through: fm_vld=in_vld, fm_data=in_data, in_rdy=fm_rdy; fm_vld=0 in all other states.
//  CFG: in_rdy=1; each word -> cfg_word next cycle, cfg_upd pulse. LEN>1: last word wins.
//  DROP (RSVD): in_rdy=1, payload discarded; err_type set on the header accept.
//  Accept in_vld&~in_rdy: none; in_data is only sampled on a handshake. A stalled fm_rdy holds state/rem.
//  Sticky errors clear only on arst. arst mid-packet: back to HDR; the next word received is a header.
//  rem is 16 bits; LEN=0xFFFF is legal (65535 words).
// CONFIGURATION
//  DCNN_S1_CKSUM_EN defined: every packet carries one trailer word after its payload, also for LEN=0.
//   Trailer = sum of payload words mod 2^DW; the header is excluded.
//   CKS state: in_rdy=1; on mismatch set err_cksum. The trailer is never forwarded to kw/fm/cfg.
//  Undefined: no trailer, no CKS state, err_cksum tied 0, no accumulator logic.
// TESTING
//  1 KER base=0x010 LEN=3, data A,B,C -> kw_en 3 cycles, addr 0x010..0x012, pkt_done once.
//  2 KER base=0x7FE LEN=4 (KAW=11) -> addresses 0x7FE,0x7FF,0x000,0x001.
//  3 FEAT LEN=5 with fm_rdy toggling 1,0,0,1.. -> 5 fm words in order, no loss or dup; in_rdy mirrors fm_rdy.
//  4 CFG LEN=2 (X,Y), then RSVD LEN=2 -> cfg_word=Y, two cfg_upd pulses; err_type=1, 2 words dropped.
//  5 LEN=0 header, then arst asserted mid-KER (after 1 of 4 words) -> outputs reset; the next word is parsed as a header.
//  6 (CKSUM_EN) FEAT LEN=2 {1,2} trailer 3 -> err_cksum=0; trailer 4 -> err_cksum=1.

Source files
------------

// File: rtl/dcnn_s1_pkt_dispatch.sv
// ---------------------------------------------------------------------------
// dcnn_s1_pkt_dispatch
// Core-clock packet parser that sits after the stage-0 IO interface. It reads
// one header word, then steers the payload words to one of three places:
//   - KER  : the kernel-buffer write port (registered, one cycle later)
//   - FEAT : the feature-map stream (zero-latency pass-through)
//   - CFG  : the config register (registered, with an update pulse)
// Reserved packets have their payload dropped and set a sticky flag. There is
// one instance of this block per channel.
//
// Header word: [DW-1:DW-2] type (00 KER, 01 FEAT, 10 CFG, 11 RSVD),
//              [KAW+15:16] base address, [15:0] LEN (payload word count).
//
// Optional feature (macro DCNN_S1_CKSUM_EN): each packet ends with one trailer
// word that must equal the sum of its payload words mod 2^DW. A mismatch sets
// the sticky err_cksum flag. Without the macro there is no trailer and
// err_cksum is tied to 0.
//
// Ports:
//   clk, arst          core clock, asynchronous active-high reset
//   in_data/vld/rdy    incoming word stream (accepted when in_vld & in_rdy)
//   kw_en/addr/data    kernel-buffer write port
//   fm_data/vld/rdy    feature-map output stream
//   cfg_word, cfg_upd  last config payload word and its 1-cycle update pulse
//   pkt_done           1-cycle pulse when a packet completes
//   err_type           sticky: reserved packet type seen
//   err_cksum          sticky: checksum mismatch
// ---------------------------------------------------------------------------
module dcnn_s1_pkt_dispatch #(
  parameter int DW  = 32,
  parameter int KAW = 11
) (
  input  logic           clk,
  input  logic           arst,
  input  logic [DW-1:0]  in_data,
  input  logic           in_vld,
  output logic           in_rdy,
  output logic           kw_en,
  output logic [KAW-1:0] kw_addr,
  output logic [DW-1:0]  kw_data,
  output logic [DW-1:0]  fm_data,
  output logic           fm_vld,
  input  logic           fm_rdy,
  output logic [DW-1:0]  cfg_word,
  output logic           cfg_upd,
  output logic           pkt_done,
  output logic           err_type,
  output logic           err_cksum
);

`ifdef DCNN_S1_CKSUM_EN
  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_KER  = 3'd1,
    ST_FEAT = 3'd2,
    ST_CFG  = 3'd3,
    ST_DROP = 3'd4,
    ST_CKS  = 3'd5,
    ST_END  = 3'd6
  } state_t;
  // After the payload the trailer word still has to be consumed.
  localparam state_t ST_POST = ST_CKS;
`else
  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_KER  = 3'd1,
    ST_FEAT = 3'd2,
    ST_CFG  = 3'd3,
    ST_DROP = 3'd4,
    ST_END  = 3'd6
  } state_t;
  localparam state_t ST_POST = ST_END;
`endif

  state_t         state_r;
  state_t         state_nxt_s;
  logic           in_rdy_s;
  logic           accept_s;
  logic [15:0]    rem_r;
  logic [KAW-1:0] base_r;
  logic [KAW-1:0] idx_r;
  logic           kw_en_r;
  logic [KAW-1:0] kw_addr_r;
  logic [DW-1:0]  kw_data_r;
  logic [DW-1:0]  cfg_word_r;
  logic           cfg_upd_r;
  logic           err_type_r;

  logic [1:0]     hdr_type_s;
  logic [KAW-1:0] hdr_base_s;
  logic [15:0]    hdr_len_s;

  assign hdr_type_s = in_data[DW-1:DW-2];
  assign hdr_base_s = in_data[KAW+15:16];
  assign hdr_len_s  = in_data[15:0];
  assign accept_s   = in_vld & in_rdy_s;

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    in_rdy_s    = 1'b0;
    case (state_r)
      ST_HDR: begin
        in_rdy_s = 1'b1;
        if (in_vld) begin
          if (hdr_len_s == 16'd0) begin
            state_nxt_s = ST_POST;
          end else begin
            case (hdr_type_s)
              2'b00:   state_nxt_s = ST_KER;
              2'b01:   state_nxt_s = ST_FEAT;
              2'b10:   state_nxt_s = ST_CFG;
              default: state_nxt_s = ST_DROP;
            endcase
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_KER, ST_CFG, ST_DROP: begin
        in_rdy_s = 1'b1;
        if (in_vld && (rem_r == 16'd1)) begin
          state_nxt_s = ST_POST;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FEAT: begin
        // Back-pressure from the feature-map sink goes straight upstream.
        in_rdy_s = fm_rdy;
        if (in_vld && fm_rdy && (rem_r == 16'd1)) begin
          state_nxt_s = ST_POST;
        end else begin
          state_nxt_s = state_r;
        end
      end
`ifdef DCNN_S1_CKSUM_EN
      ST_CKS: begin
        in_rdy_s = 1'b1;
        if (in_vld) begin
          state_nxt_s = ST_END;
        end else begin
          state_nxt_s = state_r;
        end
      end
`endif
      ST_END: begin
        // Header bubble: nothing is accepted while pkt_done is shown.
        in_rdy_s    = 1'b0;
        state_nxt_s = ST_HDR;
      end
      default: begin
        in_rdy_s    = 1'b0;
        state_nxt_s = ST_HDR;
      end
    endcase
  end

  // Header fields, payload counters and the registered kw/cfg/error outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rem_r      <= 16'd0;
      base_r     <= {KAW{1'b0}};
      idx_r      <= {KAW{1'b0}};
      kw_en_r    <= 1'b0;
      kw_addr_r  <= {KAW{1'b0}};
      kw_data_r  <= {DW{1'b0}};
      cfg_word_r <= {DW{1'b0}};
      cfg_upd_r  <= 1'b0;
      err_type_r <= 1'b0;
    end else begin
      kw_en_r   <= 1'b0;
      cfg_upd_r <= 1'b0;
      if (accept_s) begin
        case (state_r)
          ST_HDR: begin
            base_r <= hdr_base_s;
            rem_r  <= hdr_len_s;
            idx_r  <= {KAW{1'b0}};
            if (hdr_type_s == 2'b11) begin
              err_type_r <= 1'b1;
            end
          end
          ST_KER: begin
            kw_en_r   <= 1'b1;
            kw_addr_r <= base_r + idx_r;  // wraps mod 2^KAW
            kw_data_r <= in_data;
            idx_r     <= idx_r + {{(KAW-1){1'b0}}, 1'b1};
            rem_r     <= rem_r - 16'd1;
          end
          ST_CFG: begin
            cfg_word_r <= in_data;
            cfg_upd_r  <= 1'b1;
            rem_r      <= rem_r - 16'd1;
          end
          ST_FEAT, ST_DROP: begin
            rem_r <= rem_r - 16'd1;
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef DCNN_S1_CKSUM_EN
  logic [DW-1:0] sum_r;
  logic          err_cksum_r;

  // Running checksum update for one accepted payload word.
  function automatic logic [DW-1:0] cksum_add(input logic [DW-1:0] acc,
                                              input logic [DW-1:0] word);
    return acc + word;
  endfunction

  // Payload checksum accumulator and trailer comparison.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sum_r       <= {DW{1'b0}};
      err_cksum_r <= 1'b0;
    end else if (accept_s) begin
      case (state_r)
        ST_HDR: sum_r <= {DW{1'b0}};
        ST_KER, ST_FEAT, ST_CFG, ST_DROP: sum_r <= cksum_add(sum_r, in_data);
        ST_CKS: begin
          if (in_data != sum_r) begin
            err_cksum_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign err_cksum = err_cksum_r;
`else
  assign err_cksum = 1'b0;
`endif

  assign in_rdy   = in_rdy_s;
  assign fm_vld   = (state_r == ST_FEAT) & in_vld;
  assign fm_data  = in_data;
  assign kw_en    = kw_en_r;
  assign kw_addr  = kw_addr_r;
  assign kw_data  = kw_data_r;
  assign cfg_word = cfg_word_r;
  assign cfg_upd  = cfg_upd_r;
  assign pkt_done = (state_r == ST_END);
  assign err_type = err_type_r;

endmodule

// File: tb/tb_dcnn_s1_pkt_dispatch.sv
// Directed self-checking bench for dcnn_s1_pkt_dispatch (DW=32, KAW=11).
// When DCNN_S1_CKSUM_EN is defined the bench appends the payload sum as a
// trailer to every packet and runs the checksum scenario as well.
module tb_dcnn_s1_pkt_dispatch;
  localparam int DW  = 32;
  localparam int KAW = 11;

  logic           clk = 1'b0;
  logic           arst;
  logic [DW-1:0]  in_data;
  logic           in_vld;
  logic           in_rdy;
  logic           kw_en;
  logic [KAW-1:0] kw_addr;
  logic [DW-1:0]  kw_data;
  logic [DW-1:0]  fm_data;
  logic           fm_vld;
  logic           fm_rdy;
  logic [DW-1:0]  cfg_word;
  logic           cfg_upd;
  logic           pkt_done;
  logic           err_type;
  logic           err_cksum;

  always #5 clk = ~clk;

  dcnn_s1_pkt_dispatch #(.DW(DW), .KAW(KAW)) dut (
    .clk(clk), .arst(arst), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .kw_en(kw_en), .kw_addr(kw_addr), .kw_data(kw_data),
    .fm_data(fm_data), .fm_vld(fm_vld), .fm_rdy(fm_rdy),
    .cfg_word(cfg_word), .cfg_upd(cfg_upd), .pkt_done(pkt_done),
    .err_type(err_type), .err_cksum(err_cksum)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor state
  logic [KAW-1:0] kwa_q[$];
  logic [DW-1:0]  kwd_q[$];
  logic [DW-1:0]  fm_q[$];
  int cfg_cnt  = 0;
  int done_cnt = 0;
  int rdy_mis  = 0;
  bit in_feat  = 1'b0;

  always @(negedge clk) begin
    if (!arst) begin
      if (kw_en) begin
        kwa_q.push_back(kw_addr);
        kwd_q.push_back(kw_data);
      end
      if (fm_vld && fm_rdy) fm_q.push_back(fm_data);
      if (cfg_upd) cfg_cnt++;
      if (pkt_done) done_cnt++;
      if (in_feat && (in_rdy !== fm_rdy)) rdy_mis++;
      if (fm_vld !== (in_feat & in_vld)) rdy_mis++;
    end
  end

  logic [DW-1:0] pl [0:7];

  function automatic logic [31:0] mk_hdr(input logic [1:0] t, input logic [10:0] b,
                                         input logic [15:0] l);
    return {t, 3'b000, b, l};
  endfunction

  task automatic clear_mon();
    kwa_q.delete(); kwd_q.delete(); fm_q.delete();
    cfg_cnt = 0; done_cnt = 0; rdy_mis = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    int t;
    in_data = w;
    in_vld  = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_rdy && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) check_eq("accept_timeout", t, 32'd0);
    @(posedge clk);
    #1;
    in_vld  = 1'b0;
    in_data = 32'h0;
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input int n);
    logic [31:0] sum;
    sum = 32'h0;
    send_word(hdr);
    if (hdr[31:30] == 2'b01 && n > 0) in_feat = 1'b1;
    for (int i = 0; i < n; i++) begin
      send_word(pl[i]);
      sum = sum + pl[i];
    end
    in_feat = 1'b0;
`ifdef DCNN_S1_CKSUM_EN
    send_word(sum);
`endif
  endtask

  bit t3_done = 1'b0;

  initial begin
    logic [10:0] exp_a [0:3];
    bit          pat   [0:3];
    arst = 1'b1; in_vld = 1'b0; in_data = 32'h0; fm_rdy = 1'b1;
    #12;
    check_eq("rst_kw_en",     kw_en,     32'd0);
    check_eq("rst_kw_addr",   kw_addr,   32'd0);
    check_eq("rst_kw_data",   kw_data,   32'd0);
    check_eq("rst_cfg_word",  cfg_word,  32'd0);
    check_eq("rst_cfg_upd",   cfg_upd,   32'd0);
    check_eq("rst_pkt_done",  pkt_done,  32'd0);
    check_eq("rst_err_type",  err_type,  32'd0);
    check_eq("rst_err_cksum", err_cksum, 32'd0);
    check_eq("rst_in_rdy",    in_rdy,    32'd1);
    check_eq("rst_fm_vld",    fm_vld,    32'd0);
    @(negedge clk); arst = 1'b0;
    idle(1);

    // 1: KER base 0x010, LEN 3
    pl[0] = 32'hA0A0_0001; pl[1] = 32'hB0B0_0002; pl[2] = 32'hC0C0_0003;
    send_pkt(mk_hdr(2'b00, 11'h010, 16'd3), 3);
    idle(3);
    check_eq("t1_kw_cnt", kwa_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < kwa_q.size(); i++) begin
      check_eq("t1_kw_addr", kwa_q[i], 32'h010 + i);
      check_eq("t1_kw_data", kwd_q[i], pl[i]);
    end
    check_eq("t1_done", done_cnt, 32'd1);
    clear_mon();

    // 2: KER address wrap at 2^KAW
    exp_a[0] = 11'h7FE; exp_a[1] = 11'h7FF; exp_a[2] = 11'h000; exp_a[3] = 11'h001;
    pl[0] = 32'h1111_0000; pl[1] = 32'h2222_0000; pl[2] = 32'h3333_0000; pl[3] = 32'h4444_0000;
    send_pkt(mk_hdr(2'b00, 11'h7FE, 16'd4), 4);
    idle(3);
    check_eq("t2_kw_cnt", kwa_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < kwa_q.size(); i++) begin
      check_eq("t2_kw_addr", kwa_q[i], exp_a[i]);
      check_eq("t2_kw_data", kwd_q[i], pl[i]);
    end
    check_eq("t2_done", done_cnt, 32'd1);
    clear_mon();

    // 3: FEAT LEN 5 with fm_rdy pattern 1,0,0,1
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 5; i++) pl[i] = 32'hFEA7_0010 + i;
    t3_done = 1'b0;
    fork
      begin
        int k;
        k = 0;
        while (!t3_done && k < 400) begin
          fm_rdy = pat[k % 4];
          @(posedge clk);
          #1;
          k++;
        end
        fm_rdy = 1'b1;
      end
      begin
        send_pkt(mk_hdr(2'b01, 11'h000, 16'd5), 5);
        t3_done = 1'b1;
      end
    join
    idle(3);
    check_eq("t3_fm_cnt", fm_q.size(), 32'd5);
    for (int i = 0; i < 5 && i < fm_q.size(); i++) check_eq("t3_fm_data", fm_q[i], pl[i]);
    check_eq("t3_rdy_mirror", rdy_mis, 32'd0);
    check_eq("t3_done", done_cnt, 32'd1);
    check_eq("t3_no_kw", kwa_q.size(), 32'd0);
    clear_mon();

    // 4: CFG X,Y then RSVD LEN 2
    pl[0] = 32'h0000_C0DE; pl[1] = 32'hBEEF_0001;
    send_pkt(mk_hdr(2'b10, 11'h000, 16'd2), 2);
    idle(2);
    check_eq("t4_cfg_word", cfg_word, 32'hBEEF_0001);
    check_eq("t4_cfg_upd_cnt", cfg_cnt, 32'd2);
    check_eq("t4_err_type_pre", err_type, 32'd0);
    pl[0] = 32'hDEAD_0001; pl[1] = 32'hDEAD_0002;
    send_pkt(mk_hdr(2'b11, 11'h055, 16'd2), 2);
    idle(2);
    check_eq("t4_err_type", err_type, 32'd1);
    check_eq("t4_cfg_kept", cfg_word, 32'hBEEF_0001);
    check_eq("t4_cfg_upd_cnt2", cfg_cnt, 32'd2);
    check_eq("t4_drop_kw", kwa_q.size(), 32'd0);
    check_eq("t4_drop_fm", fm_q.size(), 32'd0);
    check_eq("t4_done", done_cnt, 32'd2);
    clear_mon();

    // 5: LEN=0 packet, then reset in the middle of a KER packet
    send_pkt(mk_hdr(2'b00, 11'h100, 16'd0), 0);
    idle(2);
    check_eq("t5_len0_done", done_cnt, 32'd1);
    check_eq("t5_len0_no_kw", kwa_q.size(), 32'd0);
    send_word(mk_hdr(2'b00, 11'h020, 16'd4));
    send_word(32'h5555_AAAA);
    check_eq("t5_kw_en_pre", kw_en, 32'd1);
    #2 arst = 1'b1;
    #1;
    check_eq("t5_rst_kw_en",    kw_en,    32'd0);
    check_eq("t5_rst_kw_addr",  kw_addr,  32'd0);
    check_eq("t5_rst_kw_data",  kw_data,  32'd0);
    check_eq("t5_rst_cfg_word", cfg_word, 32'd0);
    check_eq("t5_rst_err_type", err_type, 32'd0);
    check_eq("t5_rst_pkt_done", pkt_done, 32'd0);
    check_eq("t5_rst_in_rdy",   in_rdy,   32'd1);
    @(negedge clk); arst = 1'b0;
    idle(1);
    clear_mon();
    pl[0] = 32'h1234_5678;
    send_pkt(mk_hdr(2'b10, 11'h000, 16'd1), 1);
    idle(2);
    check_eq("t5_hdr_cfg_word", cfg_word, 32'h1234_5678);
    check_eq("t5_hdr_cfg_cnt", cfg_cnt, 32'd1);
    check_eq("t5_hdr_no_kw", kwa_q.size(), 32'd0);
    check_eq("t5_hdr_done", done_cnt, 32'd1);
    clear_mon();

`ifdef DCNN_S1_CKSUM_EN
    // 6: checksum good then bad
    send_word(mk_hdr(2'b01, 11'h000, 16'd2));
    in_feat = 1'b1;
    send_word(32'd1);
    send_word(32'd2);
    in_feat = 1'b0;
    send_word(32'd3);
    idle(2);
    check_eq("t6_cks_ok", err_cksum, 32'd0);
    check_eq("t6_fm_cnt", fm_q.size(), 32'd2);
    send_word(mk_hdr(2'b01, 11'h000, 16'd2));
    in_feat = 1'b1;
    send_word(32'd1);
    send_word(32'd2);
    in_feat = 1'b0;
    send_word(32'd4);
    idle(2);
    check_eq("t6_cks_bad", err_cksum, 32'd1);
    check_eq("t6_fm_cnt2", fm_q.size(), 32'd4);
    check_eq("t6_done", done_cnt, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
